text_row_fetcher: RTL and testbench
===================================

// Module: text_row_fetcher
// PURPOSE
//  - Prefetches one character row of text-mode video memory into a double-buffered line
//    buffer, one display line ahead of use.
//  - Sits between the CPU-shared video RAM read port and ppu_char. The PPU reads cell codes
//    from the front buffer at pixel rate while the back buffer is filled.
//  - Paced by line/frame from display_1024_600.
// PARAMETERS
//  CORDW      12     signed coordinate width (matches display timing)
//  COLS       64     character cells per row (power of 2)
//  ROWS       37     character rows per frame
//  CHAR_H     16     pixel lines per character row (power of 2)
//  VRAM_AW    12     video RAM address width
//  VRAM_BASE  0      address of cell (0,0) code byte
//  ATTR_BASE  2048   address of cell (0,0) attribute byte (used only with macro)
// PORTS
//  clk_pix     in   1          pixel clock, all logic on rising edge
//  rst_n       in   1          asynchronous active-low reset
//  sy          in   CORDW      signed current line, valid when line=1
//  line        in   1          1-cycle pulse at start of each line
//  frame       in   1          1-cycle pulse at start of frame
//  vram_rd     out  1          read request
//  vram_addr   out  VRAM_AW    read address, held stable while vram_rd & ~vram_gnt
//  vram_gnt    in   1          request accepted this cycle (CPU has priority)
//  vram_data   in   8          read data, valid exactly 1 cycle after accepted request
//  rd_col      in   log2(COLS) front-buffer column read by PPU
//  rd_char     out  8          code at rd_col, registered, 1-cycle latency
//  rd_attr     out  8          attribute at rd_col, 1-cycle latency (0 without macro)
//  busy        out  1          fetch in progress
//  underrun    out  1          sticky: swap due but back buffer incomplete
//  underrun_clr in  1          clears underrun (set wins if same cycle)
// BEHAVIOUR
//  - Reset (async): FSM=IDLE; vram_rd=0, vram_addr=0, rd_char=0, rd_attr=0, busy=0,
//    underrun=0, front select=0, ready=0. Buffer RAM contents are not reset.
//  - On each line pulse, actions are evaluated in order: swap, then launch.
//    1. Swap: if sy>=0, sy<ROWS*CHAR_H and sy%CHAR_H==0:
//       - ready=1: toggle front select, clear ready.
//       - else: set underrun, abort any fetch to IDLE, front unchanged.
//    2. Launch: n=sy+1 (signed). If 0<=n<ROWS*CHAR_H and n%CHAR_H==0, start fetching row
//       r=n/CHAR_H into the back buffer; clear ready.
//  - FSM IDLE -> FETCH (launch) -> DRAIN (last request accepted) -> IDLE (last data
//    written, ready=1).
//  - FETCH request k: addr = VRAM_BASE + r*COLS + k, k=0..COLS-1 (mod 2^VRAM_AW).
//    k advances only on vram_gnt; no request skipped or repeated.
//  - Data capture: vram_data is written to back[k] the cycle after that request's gnt.
//  - Fetch length: COLS cycles minimum; busy=1 from launch edge until DRAIN completes.
//  - vram_rd is 0 outside FETCH.
//  - frame pulse: abort fetch to IDLE, clear ready; front select and underrun unchanged.
//    If line and frame coincide, the abort happens first, then the line actions.
//  - Launch while busy (cannot occur with CHAR_H>=2): restart at k=0.
//  - rd_char tracks the front buffer continuously. The swap takes effect for reads issued
//    the cycle after the line pulse.
// CONFIGURATION
//  - TEXT_ROW_ATTR_EN defined: after the COLS code reads, FETCH issues COLS attribute reads
//    at ATTR_BASE + r*COLS + k into a parallel attribute buffer. Minimum fetch is 2*COLS
//    cycles; rd_attr is live.
//  - TEXT_ROW_ATTR_EN undefined: no attribute buffer or reads; rd_attr=8'h00 constant.
// TESTING
//  1. Reset mid-FETCH (rst_n low 3 cycles) -> vram_rd=0, busy=0, underrun=0 immediately;
//     next row-start swap flags underrun.
//  2. gnt=1, VRAM[i]=i: line at sy=-1 -> reads 0..63 in consecutive cycles, busy 65 cycles;
//     line at sy=0 swaps; rd_col=5 -> rd_char=5 next cycle.
//  3. gnt pseudo-random 50%: sy=15 -> addr 64..127 each accepted once, addr held while
//     gnt=0; buffer matches VRAM.
//  4. gnt=0 throughout row 1 fetch: line at sy=16 -> underrun=1, front still row 0;
//     underrun_clr -> 0.
//  5. sy=36*16-1 fetches row 36 (addr 2304..2367); sy=37*16-1 and sy=-2 launch nothing.
//  6. With TEXT_ROW_ATTR_EN, ATTR=~code: 128 reads, rd_attr=~rd_char. Without it,
//     64 reads and rd_attr=0.

Source files
------------

// File: rtl/text_row_fetcher.sv
// -----------------------------------------------------------------------------
// text_row_fetcher
//
// Prefetches one character row of text-mode video memory into a double-buffered
// line buffer, one display line ahead of use. The PPU reads cell codes from the
// front buffer while the back buffer is filled from the shared video RAM port.
//
// Optional feature: define TEXT_ROW_ATTR_EN to also fetch one attribute byte
// per cell (COLS extra reads from ATTR_BASE) into a parallel attribute buffer.
// Without it rd_attr is a constant 8'h00.
//
// Ports
//   clk_pix       pixel clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   sy            signed current line, valid when line=1
//   line          1-cycle pulse at start of each line
//   frame         1-cycle pulse at start of frame (aborts a fetch)
//   vram_rd       read request (only while fetching)
//   vram_addr     read address, held while vram_rd & ~vram_gnt
//   vram_gnt      request accepted this cycle
//   vram_data     read data, valid the cycle after an accepted request
//   rd_col        front-buffer column read by the PPU
//   rd_char       code at rd_col, 1-cycle latency
//   rd_attr       attribute at rd_col, 1-cycle latency
//   busy          fetch in progress
//   underrun      sticky: a swap was due but the back buffer was incomplete
//   underrun_clr  clears underrun (a new underrun in the same cycle wins)
// -----------------------------------------------------------------------------
module text_row_fetcher #(
    parameter int CORDW     = 12,
    parameter int COLS      = 64,
    parameter int ROWS      = 37,
    parameter int CHAR_H    = 16,
    parameter int VRAM_AW   = 12,
    parameter int VRAM_BASE = 0,
    parameter int ATTR_BASE = 2048
) (
    input  logic                      clk_pix,
    input  logic                      rst_n,
    input  logic signed [CORDW-1:0]   sy,
    input  logic                      line,
    input  logic                      frame,
    output logic                      vram_rd,
    output logic [VRAM_AW-1:0]        vram_addr,
    input  logic                      vram_gnt,
    input  logic [7:0]                vram_data,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [7:0]                rd_char,
    output logic [7:0]                rd_attr,
    output logic                      busy,
    output logic                      underrun,
    input  logic                      underrun_clr
);

    localparam int COL_W       = $clog2(COLS);
    localparam int FRAME_LINES = ROWS * CHAR_H;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

`ifdef TEXT_ROW_ATTR_EN
    localparam bit ATTR_ON = 1'b1;
`else
    localparam bit ATTR_ON = 1'b0;
`endif

    logic [1:0]         state_q, state_d;
    logic [COL_W-1:0]   k_q, k_d;
    logic               phase_q, phase_d;       // 1 = attribute pass
    logic [VRAM_AW-1:0] row_off_q, row_off_d;   // r*COLS of the row being fetched
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic               wr_en_q, wr_en_d;       // data for a granted request arrives now
    logic [COL_W-1:0]   wr_idx_q, wr_idx_d;
    logic               wr_attr_q, wr_attr_d;
    logic               front_q, front_d;
    logic               ready_q, ready_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         rd_char_q, rd_char_d;

    logic [7:0] code_mem [2*COLS];

    int                 sy_int;
    int                 nxt_int;
    logic               row_start;
    logic               launch;
    logic               ready_now;
    logic [VRAM_AW-1:0] launch_off;

    always_comb begin
        sy_int     = int'(sy);
        nxt_int    = sy_int + 1;
        row_start  = (sy_int >= 0) && (sy_int < FRAME_LINES) && ((sy_int % CHAR_H) == 0);
        launch     = (nxt_int >= 0) && (nxt_int < FRAME_LINES) && ((nxt_int % CHAR_H) == 0);
        launch_off = VRAM_AW'((nxt_int / CHAR_H) * COLS);
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        phase_d    = phase_q;
        row_off_d  = row_off_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_idx_d   = k_q;
        wr_attr_d  = phase_q;
        front_d    = front_q;
        ready_d    = ready_q;
        underrun_d = underrun_q;
        ready_now  = ready_q;

        case (state_q)
            ST_FETCH: begin
                if (vram_gnt) begin
                    wr_en_d = 1'b1;
                    if (k_q == COL_W'(COLS - 1)) begin
                        if (ATTR_ON && !phase_q) begin
                            phase_d = 1'b1;
                            k_d     = '0;
                            addr_d  = VRAM_AW'(ATTR_BASE) + row_off_q;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        k_d    = k_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Last data word is written this cycle.
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: ;
        endcase

        // Frame abort is applied before the line actions, so a coincident
        // row-start swap sees ready already cleared.
        if (frame) begin
            state_d   = ST_IDLE;
            ready_d   = 1'b0;
            ready_now = 1'b0;
        end

        if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        if (line && row_start) begin
            if (ready_now) begin
                front_d = ~front_q;
                ready_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
                state_d    = ST_IDLE;
                ready_d    = 1'b0;
            end
        end

        if (line && launch) begin
            state_d   = ST_FETCH;
            k_d       = '0;
            phase_d   = 1'b0;
            row_off_d = launch_off;
            addr_d    = VRAM_AW'(VRAM_BASE) + launch_off;
            ready_d   = 1'b0;
        end

        rd_char_d = code_mem[{front_q, rd_col}];
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            phase_q    <= 1'b0;
            row_off_q  <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_attr_q  <= 1'b0;
            front_q    <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            rd_char_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            phase_q    <= phase_d;
            row_off_q  <= row_off_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_attr_q  <= wr_attr_d;
            front_q    <= front_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            rd_char_q  <= rd_char_d;
        end
    end

    // Buffer RAM: not reset. The back bank is always the one not selected as front.
    always_ff @(posedge clk_pix) begin
        if (wr_en_q && !wr_attr_q) begin
            code_mem[{~front_q, wr_idx_q}] <= vram_data;
        end
    end

`ifdef TEXT_ROW_ATTR_EN
    logic [7:0] attr_mem [2*COLS];
    logic [7:0] rd_attr_q;

    always_ff @(posedge clk_pix) begin
        if (wr_en_q && wr_attr_q) begin
            attr_mem[{~front_q, wr_idx_q}] <= vram_data;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            rd_attr_q <= 8'h00;
        end else begin
            rd_attr_q <= attr_mem[{front_q, rd_col}];
        end
    end

    assign rd_attr = rd_attr_q;
`else
    assign rd_attr = 8'h00;
`endif

    assign vram_rd   = (state_q == ST_FETCH);
    assign vram_addr = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign underrun  = underrun_q;
    assign rd_char   = rd_char_q;

endmodule

// File: tb/tb_text_row_fetcher.sv
// Testbench for text_row_fetcher: behavioural model of the row prefetch
// (grant counting, completed-row tracking, front/back row bookkeeping) checked
// every cycle, plus hand-computed literal checks.
module tb_text_row_fetcher;

    localparam int CORDW  = 12;
    localparam int COLS   = 64;
    localparam int ROWS   = 37;
    localparam int CHAR_H = 16;
    localparam int LINES  = ROWS * CHAR_H;
`ifdef TEXT_ROW_ATTR_EN
    localparam int NREQ   = 2 * COLS;
`else
    localparam int NREQ   = COLS;
`endif

    logic                    clk_pix = 1'b0;
    logic                    rst_n;
    logic signed [CORDW-1:0] sy;
    logic                    line;
    logic                    frame;
    logic                    vram_rd;
    logic [11:0]             vram_addr;
    logic                    vram_gnt = 1'b1;
    logic [7:0]              vram_data = 8'h00;
    logic [5:0]              rd_col;
    logic [7:0]              rd_char;
    logic [7:0]              rd_attr;
    logic                    busy;
    logic                    underrun;
    logic                    underrun_clr;

    int n_cmp  = 0;
    int n_fail = 0;
    int gnt_mode = 0;   // 0: always grant, 1: random, 2: never

    text_row_fetcher dut (
        .clk_pix      (clk_pix),
        .rst_n        (rst_n),
        .sy           (sy),
        .line         (line),
        .frame        (frame),
        .vram_rd      (vram_rd),
        .vram_addr    (vram_addr),
        .vram_gnt     (vram_gnt),
        .vram_data    (vram_data),
        .rd_col       (rd_col),
        .rd_char      (rd_char),
        .rd_attr      (rd_attr),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk_pix = ~clk_pix;

    // Video RAM contents: low half holds i ^ (i>>8), upper half the complement
    // of the matching low-half byte (so attribute = ~code for rows below 32).
    function automatic logic [7:0] vram_f(input int a);
        int b;
        b = a % 4096;
        if (b < 2048) return 8'(b) ^ 8'(b >> 8);
        return ~(8'(b - 2048) ^ 8'((b - 2048) >> 8));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                         name, $time, act, act, exp, exp);
        end
    endtask

    // Memory responder
    always @(posedge clk_pix) begin
        if (vram_rd && vram_gnt) vram_data <= vram_f(int'(vram_addr));
    end

    always @(negedge clk_pix) begin
        case (gnt_mode)
            0:       vram_gnt = 1'b1;
            1:       vram_gnt = 1'($urandom_range(0, 1));
            default: vram_gnt = 1'b0;
        endcase
    end

    // ---------------- behavioural model ----------------
    bit m_busy, m_drain, m_ready, m_under, m_chk, m_old_ready;
    int m_g, m_row, m_front, m_back, m_sv, m_nv;
    logic [7:0] m_char, m_attr;

    always @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_drain = 0; m_ready = 0; m_under = 0; m_chk = 0;
            m_g = 0; m_row = 0; m_front = -1; m_back = -1;
            m_char = 8'h00; m_attr = 8'h00;
        end else begin
            m_chk = (m_front >= 0);
            if (m_chk) begin
                m_char = vram_f(m_front * COLS + int'(rd_col));
                m_attr = vram_f(2048 + m_front * COLS + int'(rd_col));
            end
            m_old_ready = m_ready;
            if (m_busy) begin
                if (m_drain) begin
                    m_busy = 0; m_drain = 0; m_ready = 1; m_back = m_row;
                end else if (vram_gnt) begin
                    m_g++;
                    if (m_g == NREQ) m_drain = 1;
                end
            end
            if (frame) begin
                m_busy = 0; m_drain = 0; m_ready = 0; m_old_ready = 0;
            end
            if (underrun_clr) m_under = 0;
            m_sv = sy;
            m_nv = m_sv + 1;
            if (line && m_sv >= 0 && m_sv < LINES && m_sv % CHAR_H == 0) begin
                if (m_old_ready) begin
                    m_front = m_back; m_ready = 0;
                end else begin
                    m_under = 1; m_busy = 0; m_drain = 0; m_ready = 0;
                end
            end
            if (line && m_nv >= 0 && m_nv < LINES && m_nv % CHAR_H == 0) begin
                m_busy = 1; m_drain = 0; m_g = 0; m_row = m_nv / CHAR_H; m_ready = 0;
            end
        end
    end

    // Single per-cycle compare process
    always @(negedge clk_pix) begin
        int exp_addr;
        bit exp_rd;
        exp_rd   = m_busy && !m_drain;
        exp_addr = (m_g < COLS) ? (m_row * COLS + m_g) % 4096
                                : (2048 + m_row * COLS + m_g - COLS) % 4096;
        chk("vram_rd", int'(vram_rd), int'(exp_rd));
        chk("busy", int'(busy), int'(m_busy));
        chk("underrun", int'(underrun), int'(m_under));
        if (exp_rd) chk("vram_addr", int'(vram_addr), exp_addr);
        if (m_chk) chk("rd_char", int'(rd_char), int'(m_char));
`ifdef TEXT_ROW_ATTR_EN
        if (m_chk) chk("rd_attr", int'(rd_attr), int'(m_attr));
`else
        chk("rd_attr_zero", int'(rd_attr), 0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk_pix);
    endtask

    task automatic pulse_line(input int s);
        sy   = CORDW'(s);
        line = 1'b1;
        cycles(1);
        line = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int i;
        i = 0;
        while (busy && i < lim) begin
            cycles(1);
            i++;
        end
        chk("fetch_done", int'(busy), 0);
    endtask

    initial begin
        int nb, nr;
        rst_n = 1'b0; line = 1'b0; frame = 1'b0; sy = '0;
        underrun_clr = 1'b0; rd_col = '0;
        cycles(3);
        rst_n = 1'b1;
        chk("reset_vram_rd", int'(vram_rd), 0);
        chk("reset_addr", int'(vram_addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_underrun", int'(underrun), 0);
        chk("reset_rd_char", int'(rd_char), 0);
        chk("reset_rd_attr", int'(rd_attr), 0);
        cycles(2);

        // Row 0 with full grants
        gnt_mode = 0;
        pulse_line(-1);
        chk("row0_first_addr", int'(vram_addr), 0);
        nb = 0; nr = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            nb++;
            if (vram_rd) nr++;
            cycles(1);
        end
        chk("row0_busy_len", nb, NREQ + 1);
        chk("row0_req_cnt", nr, NREQ);
        pulse_line(0);
        chk("row0_swap_no_underrun", int'(underrun), 0);
        rd_col = 6'd5;
        cycles(1);
        chk("row0_col5_char", int'(rd_char), 5);
`ifdef TEXT_ROW_ATTR_EN
        chk("row0_col5_attr", int'(rd_attr), 8'hFA);
`else
        chk("row0_col5_attr", int'(rd_attr), 0);
`endif

        // Row 1 with random grants
        gnt_mode = 1;
        pulse_line(15);
        wait_idle(3000);
        pulse_line(16);
        for (int c = 0; c < COLS; c++) begin
            rd_col = 6'(c);
            cycles(1);
        end
        rd_col = 6'd3;
        cycles(1);
        chk("row1_col3_char", int'(rd_char), 8'h43);

        // Row 2 starved: underrun at the row start, front stays row 1
        gnt_mode = 2;
        pulse_line(31);
        cycles(20);
        chk("row2_starved_busy", int'(busy), 1);
        chk("row2_addr_held", int'(vram_addr), 128);
        pulse_line(32);
        chk("row2_underrun", int'(underrun), 1);
        chk("row2_abort", int'(busy), 0);
        cycles(1);
        chk("row2_front_kept", int'(rd_char), 8'h43);
        underrun_clr = 1'b1;
        cycles(1);
        underrun_clr = 1'b0;
        chk("underrun_clr", int'(underrun), 0);
        underrun_clr = 1'b1;
        pulse_line(48);
        underrun_clr = 1'b0;
        chk("underrun_set_wins", int'(underrun), 1);
        underrun_clr = 1'b1;
        cycles(1);
        underrun_clr = 1'b0;

        // Frame abort, and frame coinciding with line
        gnt_mode = 0;
        pulse_line(47);
        cycles(10);
        frame = 1'b1;
        cycles(1);
        frame = 1'b0;
        chk("frame_abort", int'(busy), 0);
        frame = 1'b1;
        pulse_line(-1);
        frame = 1'b0;
        chk("frame_then_launch", int'(busy), 1);
        wait_idle(400);
        frame = 1'b1;
        pulse_line(0);
        frame = 1'b0;
        chk("frame_clears_ready", int'(underrun), 1);
        underrun_clr = 1'b1;
        cycles(1);
        underrun_clr = 1'b0;

        // Last row and out-of-range lines
        pulse_line(36 * CHAR_H - 1);
        chk("row36_first_addr", int'(vram_addr), 2304);
        wait_idle(400);
        pulse_line(36 * CHAR_H);
        chk("row36_swap", int'(underrun), 0);
        rd_col = 6'd0;
        cycles(1);
        chk("row36_col0_char", int'(rd_char), 8'hFE);
        pulse_line(37 * CHAR_H - 1);
        chk("no_launch_past_end", int'(busy), 0);
        pulse_line(37 * CHAR_H);
        chk("no_swap_past_end", int'(underrun), 0);
        pulse_line(-2);
        chk("no_launch_sy_m2", int'(busy), 0);

        // Reset mid-fetch
        pulse_line(16);
        chk("pre_reset_underrun", int'(underrun), 1);
        pulse_line(-1);
        cycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_vram_rd", int'(vram_rd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_underrun", int'(underrun), 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        pulse_line(0);
        chk("post_reset_underrun", int'(underrun), 1);
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
